// File: rtl/lifo_port_arbiter.sv
// Two-port round-robin front end for a single push/pop stack.
// One transaction per IDLE->ISSUE->RESP pass; strobes fire only in ISSUE, guarded by full/empty.
module lifo_port_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              ireq0,
  input  logic              iop0,
  input  logic [DATA_W-1:0] iw_data0,
  output logic              ogrant0,
  output logic              odone0,
  output logic              oerr0,
  output logic [DATA_W-1:0] or_data0,
  input  logic              ireq1,
  input  logic              iop1,
  input  logic [DATA_W-1:0] iw_data1,
  output logic              ogrant1,
  output logic              odone1,
  output logic              oerr1,
  output logic [DATA_W-1:0] or_data1,
  output logic              ostk_wr,
  output logic              ostk_rd,
  output logic [DATA_W-1:0] ostk_w_data,
  input  logic              istk_empty,
  input  logic              istk_full,
  input  logic [DATA_W-1:0] istk_r_data,
  output logic [CNT_W-1:0]  ocount,
  output logic              obusy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            rState;
  state_t            nState;
  logic              rLast;
  logic              rWin;
  logic              rOp;
  logic [DATA_W-1:0] rData;
  logic              win;
  logic              grantNow;
  logic              issue;
  logic              errNow;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) rState <= IDLE;
    else           rState <= nState;
  end

  // Next state and arbitration; on a tie the port that did not win last time goes next
  always_comb begin
    nState   = rState;
    win      = 1'b0;
    grantNow = 1'b0;
    case (rState)
      IDLE: begin
        if (ireq0 || ireq1) begin
          grantNow = 1'b1;
          win      = (ireq0 && ireq1) ? ~rLast : ireq1;
          nState   = ISSUE;
        end
      end
      ISSUE:   nState = RESP;
      RESP:    nState = IDLE;
      default: nState = IDLE;
    endcase
  end

  assign issue       = (rState == ISSUE);
  assign errNow      = rOp ? istk_empty : istk_full;
  assign ostk_wr     = issue & ~rOp & ~istk_full;
  assign ostk_rd     = issue &  rOp & ~istk_empty;
  assign ostk_w_data = rData;
  assign obusy       = (rState != IDLE);

  // Transaction latch, completion pulses, pop data return and occupancy
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      rLast    <= 1'b1;
      rWin     <= 1'b0;
      rOp      <= 1'b0;
      rData    <= '0;
      ogrant0  <= 1'b0;
      ogrant1  <= 1'b0;
      odone0   <= 1'b0;
      odone1   <= 1'b0;
      oerr0    <= 1'b0;
      oerr1    <= 1'b0;
      or_data0 <= '0;
      or_data1 <= '0;
      ocount   <= '0;
    end else begin
      ogrant0 <= 1'b0;
      ogrant1 <= 1'b0;
      odone0  <= 1'b0;
      odone1  <= 1'b0;
      oerr0   <= 1'b0;
      oerr1   <= 1'b0;
      if (grantNow) begin
        rLast   <= win;
        rWin    <= win;
        rOp     <= win ? iop1 : iop0;
        rData   <= win ? iw_data1 : iw_data0;
        ogrant0 <= ~win;
        ogrant1 <= win;
      end
      if (issue) begin
        odone0 <= ~rWin;
        odone1 <= rWin;
        oerr0  <= ~rWin & errNow;
        oerr1  <= rWin & errNow;
        if (ostk_rd) begin
          if (rWin) or_data1 <= istk_r_data;
          else      or_data0 <= istk_r_data;
          if (ocount != '0) ocount <= ocount - CNT_W'(1);
        end
        if (ostk_wr && (ocount != CNT_W'(DEPTH))) ocount <= ocount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lifo_port_arbiter.sv
// Bench for lifo_port_arbiter: directed vector table, random two-port traffic against a
// queue-based reference, and hand sequences for full, tie alternation and mid-ISSUE reset.
module tb_lifo_port_arbiter;

  logic        iclk = 1'b0;
  logic        ireset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  op = '0;
  logic [15:0] wd0 = '0;
  logic [15:0] wd1 = '0;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [15:0] rd0;
  logic [15:0] rd1;
  logic        stkWr;
  logic        stkRd;
  logic [15:0] stkWData;
  logic        stkEmpty;
  logic        stkFull;
  logic [15:0] stkRData;
  logic [5:0]  count;
  logic        busy;

  int nChecks = 0;
  int nErrors = 0;

  always #5 iclk = ~iclk;

  lifo_port_arbiter dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .ireq0(req[0]), .iop0(op[0]), .iw_data0(wd0),
    .ogrant0(grant[0]), .odone0(done[0]), .oerr0(err[0]), .or_data0(rd0),
    .ireq1(req[1]), .iop1(op[1]), .iw_data1(wd1),
    .ogrant1(grant[1]), .odone1(done[1]), .oerr1(err[1]), .or_data1(rd1),
    .ostk_wr(stkWr), .ostk_rd(stkRd), .ostk_w_data(stkWData),
    .istk_empty(stkEmpty), .istk_full(stkFull), .istk_r_data(stkRData),
    .ocount(count), .obusy(busy)
  );

  // Stack instance stand-in driven only by the DUT strobes
  logic [15:0] sMem [32];
  logic [5:0]  sp;
  logic [4:0]  topIdx;
  assign topIdx   = 5'(sp - 6'd1);
  assign stkEmpty = (sp == 6'd0);
  assign stkFull  = (sp == 6'd32);
  assign stkRData = stkEmpty ? 16'h0000 : sMem[topIdx];

  always @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) sp <= 6'd0;
    else if (stkWr && !stkFull) begin
      sMem[sp[4:0]] <= stkWData;
      sp <= sp + 6'd1;
    end else if (stkRd && !stkEmpty) sp <= sp - 6'd1;
  end

  typedef struct {
    bit          port;
    bit          isPop;
    logic [15:0] data;
    bit          expErr;
    logic [15:0] expRd;
    int          expCnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge iclk);
    #1;
  endtask

  task automatic setReq(input bit p, input bit r, input bit o, input logic [15:0] d);
    req[p] = r;
    op[p]  = o;
    if (p) wd1 = d;
    else   wd0 = d;
  endtask

  function automatic logic [15:0] rdOf(input bit p);
    return p ? rd1 : rd0;
  endfunction

  task automatic doReset;
    ireset_n = 1'b0;
    req = '0;
    step;
    step;
    ireset_n = 1'b1;
  endtask

  // One single-port transaction, checked in ISSUE and RESP
  task automatic oneTxn(input string tag, input bit p, input bit o, input logic [15:0] d,
                        input bit expErr, input logic [15:0] expRd, input int expCnt);
    setReq(p, 1'b1, o, d);
    step;
    chk({tag, " grant"}, 32'(grant), p ? 32'd2 : 32'd1);
    chk({tag, " wr"}, 32'(stkWr), 32'(!o && !expErr));
    chk({tag, " rd"}, 32'(stkRd), 32'(o && !expErr));
    if (!o && !expErr) chk({tag, " wdata"}, 32'(stkWData), 32'(d));
    step;
    setReq(p, 1'b0, o, d);
    chk({tag, " done"}, 32'(done), p ? 32'd2 : 32'd1);
    chk({tag, " err"}, 32'(err[p]), 32'(expErr));
    chk({tag, " rdata"}, 32'(rdOf(p)), 32'(expRd));
    chk({tag, " count"}, 32'(count), 32'(expCnt));
    step;
  endtask

  vec_t        vecs [8];
  logic [15:0] mStk [$];
  logic [15:0] mRd [2];
  bit          mLast;
  bit          pend [2];
  bit          pOp [2];
  logic [15:0] pDat [2];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234, 0};
    vecs[2] = '{1'b0, 1'b0, 16'hAAAA, 1'b0, 16'h1234, 1};
    vecs[3] = '{1'b0, 1'b0, 16'hBBBB, 1'b0, 16'h1234, 2};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'hBBBB, 1};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'hAAAA, 0};
    vecs[6] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'hAAAA, 0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h1234, 0};

    doReset;
    chk("reset count", 32'(count), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rdata0", 32'(rd0), 32'd0);

    for (int i = 0; i < 8; i++)
      oneTxn($sformatf("vec%0d", i), vecs[i].port, vecs[i].isPop, vecs[i].data,
             vecs[i].expErr, vecs[i].expRd, vecs[i].expCnt);

    // Random two-port traffic against a queue model
    doReset;
    mStk.delete();
    mRd[0] = '0;
    mRd[1] = '0;
    mLast = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 300; it++) begin
      bit w;
      bit e;
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          pOp[p]  = 1'($urandom_range(0, 1));
          pDat[p] = 16'($urandom);
          setReq(1'(p), 1'b1, pOp[p], pDat[p]);
        end
      if (!pend[0] && !pend[1]) begin
        step;
        chk("rnd idle busy", 32'(busy), 32'd0);
        continue;
      end
      w = (pend[0] && pend[1]) ? !mLast : pend[1];
      mLast = w;
      if (pOp[w]) begin
        e = (mStk.size() == 0);
        if (!e) mRd[w] = mStk.pop_back();
      end else begin
        e = (mStk.size() == 32);
        if (!e) mStk.push_back(pDat[w]);
      end
      step;
      chk("rnd grant", 32'(grant), w ? 32'd2 : 32'd1);
      chk("rnd wr", 32'(stkWr), 32'(!pOp[w] && !e));
      chk("rnd rd", 32'(stkRd), 32'(pOp[w] && !e));
      step;
      chk("rnd done", 32'(done), w ? 32'd2 : 32'd1);
      chk("rnd err", 32'(err[w]), 32'(e));
      chk("rnd rdata0", 32'(rd0), 32'(mRd[0]));
      chk("rnd rdata1", 32'(rd1), 32'(mRd[1]));
      chk("rnd count", 32'(count), 32'(mStk.size()));
      pend[w] = 1'b0;
      req[w] = 1'b0;
      step;
    end
    req = '0;

    // Fill to the top, then overflow and one pop
    doReset;
    for (int i = 0; i < 32; i++)
      oneTxn($sformatf("fill%0d", i), 1'b1, 1'b0, 16'(16'h5000 + i), 1'b0, 16'h0000, i + 1);
    oneTxn("overflow", 1'b1, 1'b0, 16'hDEAD, 1'b1, 16'h0000, 32);
    oneTxn("pop top", 1'b0, 1'b1, 16'h0000, 1'b0, 16'h501F, 31);

    // Continuous tie: grants alternate starting with port 0
    doReset;
    setReq(1'b0, 1'b1, 1'b0, 16'h0A0A);
    setReq(1'b1, 1'b1, 1'b0, 16'h0B0B);
    for (int k = 0; k < 6; k++) begin
      step;
      chk($sformatf("tie%0d grant", k), 32'(grant), (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("tie%0d no early done", k), 32'(done), 32'd0);
      step;
      chk($sformatf("tie%0d done", k), 32'(done), (k % 2) ? 32'd2 : 32'd1);
      step;
      chk($sformatf("tie%0d idle done", k), 32'(done), 32'd0);
    end
    chk("tie count", 32'(count), 32'd6);
    req = '0;
    step;

    // Reset in the middle of ISSUE
    setReq(1'b0, 1'b1, 1'b0, 16'h7777);
    step;
    chk("rst-issue wr before", 32'(stkWr), 32'd1);
    #2;
    ireset_n = 1'b0;
    #1;
    chk("rst-issue wr dropped", 32'(stkWr), 32'd0);
    chk("rst-issue busy", 32'(busy), 32'd0);
    chk("rst-issue grant", 32'(grant), 32'd0);
    step;
    chk("rst-issue no done", 32'(done), 32'd0);
    chk("rst-issue count", 32'(count), 32'd0);
    ireset_n = 1'b1;
    req = '0;
    step;
    chk("rst-issue no late done", 32'(done), 32'd0);
    setReq(1'b0, 1'b1, 1'b0, 16'h1111);
    setReq(1'b1, 1'b1, 1'b0, 16'h2222);
    step;
    chk("rst-issue tie to port0", 32'(grant), 32'd1);
    step;
    req = '0;
    chk("rst-issue count after", 32'(count), 32'd1);
    step;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
